lzc_norm_arbiter: RTL

// - Shares one leading-zero-count + left-normalize datapath (LZC of nibble counters + boundary encoder, barrel shifter) between two FPU requesters.
// - Requester 0: FADD/FSUB post-subtract path. Requester 1: FMUL/FCVT path.
// - Round-robin arbitration, valid/ready handshakes, 2-stage pipeline with full backpressure.
// - Returns the normalized significand, shift count, zero flag, source ID and tag.

---
 rtl/lzc_norm_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/lzc_norm_arbiter.sv
// Shared leading-zero-count and left-normalize unit for two FPU requesters.
// Round-robin arbitration into a two-stage pipeline with full backpressure.
module lzc_norm_arbiter #(
   parameter int MANT_W = 32,
   parameter int TAG_W  = 4,
   parameter int CNT_W  = $clog2(MANT_W) + 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [1:0]        i_req_vld,
   output logic [1:0]        o_req_rdy,
   input  logic [MANT_W-1:0] i_req_mant0,
   input  logic [MANT_W-1:0] i_req_mant1,
   input  logic [TAG_W-1:0]  i_req_tag0,
   input  logic [TAG_W-1:0]  i_req_tag1,
   output logic              o_res_vld,
   input  logic              i_res_rdy,
   output logic [MANT_W-1:0] o_res_mant,
   output logic [CNT_W-1:0]  o_res_cnt,
   output logic              o_res_zero,
   output logic              o_res_src,
   output logic [TAG_W-1:0]  o_res_tag
);

   localparam int NB = MANT_W / 8;

   logic              r_s1Vld;
   logic              r_s1Src;
   logic [MANT_W-1:0] r_s1Mant;
   logic [TAG_W-1:0]  r_s1Tag;
   logic              r_rrPtr;

   logic              r_s2Vld;
   logic              r_s2Src;
   logic              r_s2Zero;
   logic [MANT_W-1:0] r_s2Mant;
   logic [CNT_W-1:0]  r_s2Cnt;
   logic [TAG_W-1:0]  r_s2Tag;

   logic              w_s1En;
   logic              w_s2En;
   logic [1:0]        w_grant;
   logic [CNT_W-1:0]  w_lzCnt;
   logic              w_isZero;
   logic [MANT_W-1:0] w_normMant;

   function automatic logic [2:0] nibLz(input logic [3:0] n);
      casez (n)
         4'b1???: return 3'd0;
         4'b01??: return 3'd1;
         4'b001?: return 3'd2;
         4'b0001: return 3'd3;
         default: return 3'd4;
      endcase
   endfunction

   // Two nibble counters per byte; an all-zero byte yields 8.
   function automatic logic [3:0] byteLz(input logic [7:0] b);
      if (b[7:4] != 4'h0)
         return {1'b0, nibLz(b[7:4])};
      else
         return 4'd4 + {1'b0, nibLz(b[3:0])};
   endfunction

   assign w_s2En = ~r_s2Vld | i_res_rdy;
   assign w_s1En = ~r_s1Vld | w_s2En;

   // Grant is masked during reset so nothing is handshaken while flushing.
   always_comb begin
      w_grant = 2'b00;
      if (i_rst_n && w_s1En) begin
         if (i_req_vld == 2'b11)
            w_grant = r_rrPtr ? 2'b10 : 2'b01;
         else
            w_grant = i_req_vld;
      end
   end

   assign o_req_rdy = w_grant;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_s1Vld  <= 1'b0;
         r_s1Src  <= 1'b0;
         r_s1Mant <= '0;
         r_s1Tag  <= '0;
         r_rrPtr  <= 1'b0;
      end else begin
         if (|w_grant)
            r_rrPtr <= w_grant[0];
         if (w_s1En) begin
            r_s1Vld <= |w_grant;
            if (w_grant[1]) begin
               r_s1Mant <= i_req_mant1;
               r_s1Tag  <= i_req_tag1;
               r_s1Src  <= 1'b1;
            end else if (w_grant[0]) begin
               r_s1Mant <= i_req_mant0;
               r_s1Tag  <= i_req_tag0;
               r_s1Src  <= 1'b0;
            end
         end
      end
   end

   // Boundary encoder: scanning upward lets the most significant non-zero byte win.
   always_comb begin
      w_lzCnt  = CNT_W'(MANT_W);
      w_isZero = 1'b1;
      for (int i = 0; i < NB; i++) begin
         if (r_s1Mant[i*8 +: 8] != 8'h00) begin
            w_lzCnt  = CNT_W'((NB - 1 - i) * 8) + CNT_W'(byteLz(r_s1Mant[i*8 +: 8]));
            w_isZero = 1'b0;
         end
      end
      w_normMant = w_isZero ? '0 : (r_s1Mant << w_lzCnt);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_s2Vld  <= 1'b0;
         r_s2Src  <= 1'b0;
         r_s2Zero <= 1'b0;
         r_s2Mant <= '0;
         r_s2Cnt  <= '0;
         r_s2Tag  <= '0;
      end else if (w_s2En) begin
         r_s2Vld <= r_s1Vld;
         if (r_s1Vld) begin
            r_s2Mant <= w_normMant;
            r_s2Cnt  <= w_lzCnt;
            r_s2Zero <= w_isZero;
            r_s2Src  <= r_s1Src;
            r_s2Tag  <= r_s1Tag;
         end
      end
   end

   assign o_res_vld  = r_s2Vld;
   assign o_res_mant = r_s2Mant;
   assign o_res_cnt  = r_s2Cnt;
   assign o_res_zero = r_s2Zero;
   assign o_res_src  = r_s2Src;
   assign o_res_tag  = r_s2Tag;

endmodule
